// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : router_pkg
//  Description : Shared constants and types for the virtual channel router.
//                Flit width mirrors the `FLIT_DATA_WIDTH macro so that
//                macro-based and package-based users agree on one value.
//  Revision    : 1.0  initial release
// ============================================================================
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

package router_pkg;

   localparam int FLIT_DATA_WIDTH  = `FLIT_DATA_WIDTH;
   localparam int DEFAULT_NUM_VC   = 4;
   localparam int DEFAULT_VC_DEPTH = 4;
   localparam int DEFAULT_VC_ID_W  = (DEFAULT_NUM_VC > 1) ? $clog2(DEFAULT_NUM_VC) : 1;

   typedef logic [DEFAULT_VC_ID_W-1:0] vc_id_t;

endpackage : router_pkg

`default_nettype wire

// File: rtl/vc_fifo_slice.sv
`default_nettype none
// ============================================================================
//  Module      : vc_fifo_slice
//  Description : Storage for one virtual channel. Circular buffer with
//                explicit occupancy counter; head is first-word-fall-through.
//                Status flags come from the counter only.
//  Ports       : clk, reset (async, active-low)
//                push_i / pop_i   : already-qualified enqueue / dequeue
//                data_i           : flit to enqueue
//                head_o           : flit at read pointer (don't-care if empty)
//                count_o          : occupancy
//                empty_o, full_o, afull_o : status
//  Revision    : 1.0  initial release
// ============================================================================
module vc_fifo_slice #(
   parameter int DEPTH        = 4,
   parameter int DATA_WIDTH   = 32,
   parameter int AFULL_THRESH = DEPTH - 1,
   parameter int CNT_W        = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [DATA_WIDTH-1:0] head_o,
   output logic [CNT_W-1:0]      count_o,
   output logic                  empty_o,
   output logic                  full_o,
   output logic                  afull_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q,  count_d;

   // Explicit wrap so non-power-of-two depths work.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) begin
         wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; contents are only observable once counted.
   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign afull_o = (count_q >= CNT_W'(AFULL_THRESH));

endmodule : vc_fifo_slice

`default_nettype wire

// File: rtl/vc_input_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : vc_input_buffer
//  Description : Per-input-port flit buffer: NUM_VC independent FIFOs sharing
//                one tagged write port and one selected read port. Returns one
//                registered credit per accepted pop and keeps sticky error
//                flags for rejected writes and pops.
//  Ports       : clk, reset (async, active-low)
//                wr_valid/wr_vc/wr_data : tagged write port
//                rd_pop/rd_vc/rd_data   : read select, dequeue, FWFT head
//                vc_empty/vc_full/vc_almost_full/vc_count : per-VC status
//                credit_valid/credit_vc : upstream credit return
//                overflow_err/underflow_err/clear_err     : sticky errors
//  Revision    : 1.0  initial release
// ============================================================================
module vc_input_buffer
   import router_pkg::*;
#(
   parameter int NUM_VC       = DEFAULT_NUM_VC,
   parameter int VC_DEPTH     = DEFAULT_VC_DEPTH,
   parameter int DATA_WIDTH   = FLIT_DATA_WIDTH,
   parameter int AFULL_THRESH = VC_DEPTH - 1,
   parameter int VC_ID_W      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
   parameter int CNT_W        = $clog2(VC_DEPTH + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      wr_valid,
   input  logic [VC_ID_W-1:0]        wr_vc,
   input  logic [DATA_WIDTH-1:0]     wr_data,
   input  logic                      rd_pop,
   input  logic [VC_ID_W-1:0]        rd_vc,
   output logic [DATA_WIDTH-1:0]     rd_data,
   output logic [NUM_VC-1:0]         vc_empty,
   output logic [NUM_VC-1:0]         vc_full,
   output logic [NUM_VC-1:0]         vc_almost_full,
   output logic [NUM_VC*CNT_W-1:0]   vc_count,
   output logic                      credit_valid,
   output logic [VC_ID_W-1:0]        credit_vc,
   output logic                      overflow_err,
   output logic                      underflow_err,
   input  logic                      clear_err
);

   // One extra bit so the range test is meaningful for any NUM_VC.
   localparam logic [VC_ID_W:0] NUM_VC_EXT = (VC_ID_W + 1)'(NUM_VC);

   logic [DATA_WIDTH-1:0] w_head [NUM_VC];
   logic [CNT_W-1:0]      w_count [NUM_VC];
   logic [NUM_VC-1:0]     w_empty, w_full, w_afull;
   logic [NUM_VC-1:0]     w_push, w_pop;

   logic w_wr_in_range, w_rd_in_range;
   logic w_wr_accept,   w_pop_accept;

   logic               credit_valid_q;
   logic [VC_ID_W-1:0] credit_vc_q;
   logic               overflow_err_q,  overflow_err_d;
   logic               underflow_err_q, underflow_err_d;

   assign w_wr_in_range = ({1'b0, wr_vc} < NUM_VC_EXT);
   assign w_rd_in_range = ({1'b0, rd_vc} < NUM_VC_EXT);

   // Acceptance uses registered status only: a pop on an empty VC is never
   // bypassed by a same-cycle write, and a write to a full VC is never
   // admitted by a same-cycle pop.
   assign w_wr_accept  = wr_valid && w_wr_in_range && !w_full[wr_vc];
   assign w_pop_accept = rd_pop   && w_rd_in_range && !w_empty[rd_vc];

   generate
      for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
         assign w_push[i] = w_wr_accept  && (wr_vc == VC_ID_W'(i));
         assign w_pop[i]  = w_pop_accept && (rd_vc == VC_ID_W'(i));

         vc_fifo_slice #(
            .DEPTH        (VC_DEPTH),
            .DATA_WIDTH   (DATA_WIDTH),
            .AFULL_THRESH (AFULL_THRESH),
            .CNT_W        (CNT_W)
         ) u_slice (
            .clk     (clk),
            .reset   (reset),
            .push_i  (w_push[i]),
            .pop_i   (w_pop[i]),
            .data_i  (wr_data),
            .head_o  (w_head[i]),
            .count_o (w_count[i]),
            .empty_o (w_empty[i]),
            .full_o  (w_full[i]),
            .afull_o (w_afull[i])
         );

         assign vc_count[i*CNT_W +: CNT_W] = w_count[i];
      end
   endgenerate

   always_comb begin
      rd_data = '0;
      if (w_rd_in_range) begin
         rd_data = w_head[rd_vc];
      end
   end

   // Clear drops the held value; a new event in the same cycle still sets.
   always_comb begin
      overflow_err_d  = (overflow_err_q  && !clear_err) || (wr_valid && !w_wr_accept);
      underflow_err_d = (underflow_err_q && !clear_err) || (rd_pop   && !w_pop_accept);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         credit_valid_q  <= 1'b0;
         credit_vc_q     <= '0;
         overflow_err_q  <= 1'b0;
         underflow_err_q <= 1'b0;
      end else begin
         credit_valid_q  <= w_pop_accept;
         if (w_pop_accept) begin
            credit_vc_q <= rd_vc;
         end
         overflow_err_q  <= overflow_err_d;
         underflow_err_q <= underflow_err_d;
      end
   end

   assign vc_empty       = w_empty;
   assign vc_full        = w_full;
   assign vc_almost_full = w_afull;
   assign credit_valid   = credit_valid_q;
   assign credit_vc      = credit_vc_q;
   assign overflow_err   = overflow_err_q;
   assign underflow_err  = underflow_err_q;

endmodule : vc_input_buffer

`default_nettype wire

// File: tb/tb_vc_input_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vc_input_buffer
//  Description : Directed self-checking bench. Instance A uses VC_DEPTH=4,
//                instance B uses VC_DEPTH=3 to exercise non-power-of-two wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vc_input_buffer;

   localparam int NV = 4;
   localparam int DW = 8;
   localparam int VW = 2;
   localparam int CA = 3;   // count width for depth 4
   localparam int CB = 2;   // count width for depth 3

   logic clk = 1'b0;
   logic reset;

   logic          a_wr_valid, a_rd_pop, a_clear_err;
   logic [VW-1:0] a_wr_vc, a_rd_vc;
   logic [DW-1:0] a_wr_data, a_rd_data;
   logic [NV-1:0] a_vc_empty, a_vc_full, a_vc_afull;
   logic [NV*CA-1:0] a_vc_count;
   logic          a_credit_valid, a_ovf, a_unf;
   logic [VW-1:0] a_credit_vc;

   logic          b_wr_valid, b_rd_pop, b_clear_err;
   logic [VW-1:0] b_wr_vc, b_rd_vc;
   logic [DW-1:0] b_wr_data, b_rd_data;
   logic [NV-1:0] b_vc_empty, b_vc_full, b_vc_afull;
   logic [NV*CB-1:0] b_vc_count;
   logic          b_credit_valid, b_ovf, b_unf;
   logic [VW-1:0] b_credit_vc;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vc_input_buffer #(.NUM_VC(NV), .VC_DEPTH(4), .DATA_WIDTH(DW)) u_dut_a (
      .clk(clk), .reset(reset),
      .wr_valid(a_wr_valid), .wr_vc(a_wr_vc), .wr_data(a_wr_data),
      .rd_pop(a_rd_pop), .rd_vc(a_rd_vc), .rd_data(a_rd_data),
      .vc_empty(a_vc_empty), .vc_full(a_vc_full), .vc_almost_full(a_vc_afull),
      .vc_count(a_vc_count), .credit_valid(a_credit_valid), .credit_vc(a_credit_vc),
      .overflow_err(a_ovf), .underflow_err(a_unf), .clear_err(a_clear_err)
   );

   vc_input_buffer #(.NUM_VC(NV), .VC_DEPTH(3), .DATA_WIDTH(DW)) u_dut_b (
      .clk(clk), .reset(reset),
      .wr_valid(b_wr_valid), .wr_vc(b_wr_vc), .wr_data(b_wr_data),
      .rd_pop(b_rd_pop), .rd_vc(b_rd_vc), .rd_data(b_rd_data),
      .vc_empty(b_vc_empty), .vc_full(b_vc_full), .vc_almost_full(b_vc_afull),
      .vc_count(b_vc_count), .credit_valid(b_credit_valid), .credit_vc(b_credit_vc),
      .overflow_err(b_ovf), .underflow_err(b_unf), .clear_err(b_clear_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // VC_DEPTH=3 interleaved pattern on VC1: {push, pop} per cycle.
   logic [1:0]    pat [10] = '{2'b10, 2'b10, 2'b11, 2'b01, 2'b11,
                               2'b10, 2'b11, 2'b01, 2'b11, 2'b01};
   logic [DW-1:0] model_q [$];
   logic [DW-1:0] next_data;

   initial begin
      reset = 1'b0;
      {a_wr_valid, a_rd_pop, a_clear_err, a_wr_vc, a_rd_vc, a_wr_data} = '0;
      {b_wr_valid, b_rd_pop, b_clear_err, b_wr_vc, b_rd_vc, b_wr_data} = '0;
      repeat (2) @(posedge clk);
      #1;

      // ---- reset state
      check("rst_empty",  32'(a_vc_empty), 32'hF);
      check("rst_full",   32'(a_vc_full),  32'h0);
      check("rst_afull",  32'(a_vc_afull), 32'h0);
      check("rst_count",  32'(a_vc_count), 32'h0);
      check("rst_credit", 32'(a_credit_valid), 32'h0);
      check("rst_errs",   32'({a_ovf, a_unf}), 32'h0);
      reset = 1'b1;

      // ---- three writes to VC2, head visible FWFT
      a_wr_valid = 1'b1; a_wr_vc = 2'd2;
      a_wr_data = 8'hA1; tick();
      a_wr_data = 8'hA2; tick();
      a_wr_data = 8'hA3; tick();
      a_wr_valid = 1'b0; a_rd_vc = 2'd2; #1;
      check("vc2_head",   32'(a_rd_data), 32'hA1);
      check("vc2_count",  32'(a_vc_count), 32'h0C0);   // VC2=3 at bits [8:6]
      check("vc2_afull",  32'(a_vc_afull), 32'h4);

      // ---- fill VC1 past full
      a_wr_valid = 1'b1; a_wr_vc = 2'd1;
      a_wr_data = 8'hB1; tick();
      a_wr_data = 8'hB2; tick();
      a_wr_data = 8'hB3; tick();
      check("vc1_afull3", 32'(a_vc_afull[1]), 32'h1);
      check("vc1_full3",  32'(a_vc_full[1]),  32'h0);
      a_wr_data = 8'hB4; tick();
      check("vc1_full4",  32'(a_vc_full[1]),  32'h1);
      check("ovf_before", 32'(a_ovf), 32'h0);
      a_wr_data = 8'hB5; tick();
      a_wr_valid = 1'b0;
      check("ovf_after",  32'(a_ovf), 32'h1);
      check("vc1_count",  32'(a_vc_count[1*CA +: CA]), 32'd4);
      a_rd_vc = 2'd1; #1;
      check("vc1_head",   32'(a_rd_data), 32'hB1);

      // ---- clear, then pop of empty VC0
      a_clear_err = 1'b1; tick(); a_clear_err = 1'b0;
      check("ovf_clr",    32'(a_ovf), 32'h0);
      a_rd_pop = 1'b1; a_rd_vc = 2'd0; tick(); a_rd_pop = 1'b0;
      check("unf_set",    32'(a_unf), 32'h1);
      check("unf_nocred", 32'(a_credit_valid), 32'h0);
      a_clear_err = 1'b1; tick(); a_clear_err = 1'b0;
      check("unf_clr",    32'(a_unf), 32'h0);

      // ---- same-cycle write/pop on VC3 at count 2
      a_wr_valid = 1'b1; a_wr_vc = 2'd3;
      a_wr_data = 8'hC1; tick();
      a_wr_data = 8'hC2; tick();
      a_wr_data = 8'hC3; a_rd_pop = 1'b1; a_rd_vc = 2'd3; tick();
      a_wr_valid = 1'b0; a_rd_pop = 1'b0;
      check("vc3_count",  32'(a_vc_count[3*CA +: CA]), 32'd2);
      check("vc3_cred",   32'(a_credit_valid), 32'h1);
      check("vc3_credvc", 32'(a_credit_vc), 32'd3);
      check("vc3_head",   32'(a_rd_data), 32'hC2);
      tick();
      check("cred_pulse", 32'(a_credit_valid), 32'h0);

      // ---- same-cycle write/pop on empty VC0
      a_wr_valid = 1'b1; a_wr_vc = 2'd0; a_wr_data = 8'hD1;
      a_rd_pop = 1'b1; a_rd_vc = 2'd0; tick();
      a_rd_pop = 1'b0;
      check("vc0_cnt1",   32'(a_vc_count[0*CA +: CA]), 32'd1);
      check("vc0_unf",    32'(a_unf), 32'h1);
      check("vc0_nocred", 32'(a_credit_valid), 32'h0);
      a_wr_data = 8'hD2; tick();
      a_wr_data = 8'hD3; tick();
      a_wr_data = 8'hD4; tick();
      check("vc0_full",   32'(a_vc_full[0]), 32'h1);
      check("vc0_noovf",  32'(a_ovf), 32'h0);
      // ---- same-cycle write/pop on full VC0
      a_wr_data = 8'hD5; a_rd_pop = 1'b1; tick();
      a_wr_valid = 1'b0; a_rd_pop = 1'b0;
      check("vc0_cnt3",   32'(a_vc_count[0*CA +: CA]), 32'd3);
      check("vc0_ovf",    32'(a_ovf), 32'h1);
      check("vc0_cred",   32'(a_credit_valid), 32'h1);
      check("vc0_credvc", 32'(a_credit_vc), 32'd0);
      check("vc0_head",   32'(a_rd_data), 32'hD2);

      // ---- back-to-back pops on VC2 give a continuous credit stream
      a_rd_pop = 1'b1; a_rd_vc = 2'd2; tick();
      check("b2b_cred1",  32'({a_credit_valid, a_credit_vc}), 32'b110);
      tick();
      a_rd_pop = 1'b0;
      check("b2b_cred2",  32'({a_credit_valid, a_credit_vc}), 32'b110);
      check("b2b_head",   32'(a_rd_data), 32'hA3);
      check("b2b_count",  32'(a_vc_count[2*CA +: CA]), 32'd1);

      // ---- clear and new overflow in the same cycle: set wins
      a_clear_err = 1'b1; a_wr_valid = 1'b1; a_wr_vc = 2'd1; a_wr_data = 8'hEE; tick();
      a_clear_err = 1'b0; a_wr_valid = 1'b0;
      check("set_wins",   32'(a_ovf), 32'h1);
      check("unf_cleared", 32'(a_unf), 32'h0);

      // ---- VC_DEPTH=3 interleaved push/pop across pointer wrap
      b_rd_vc = 2'd1; b_wr_vc = 2'd1; next_data = 8'h10;
      for (int k = 0; k < 10; k++) begin
         b_wr_valid = pat[k][1];
         b_rd_pop   = pat[k][0];
         b_wr_data  = next_data;
         #1;
         if (b_rd_pop && model_q.size() > 0) begin
            check($sformatf("d3_data_%0d", k), 32'(b_rd_data), 32'(model_q[0]));
         end
         tick();
         if (pat[k][0] && model_q.size() > 0) void'(model_q.pop_front());
         if (pat[k][1] && model_q.size() < 3) begin
            model_q.push_back(next_data);
            next_data = next_data + 8'h1;
         end
         check($sformatf("d3_count_%0d", k), 32'(b_vc_count[1*CB +: CB]), 32'(model_q.size()));
      end
      b_wr_valid = 1'b0; b_rd_pop = 1'b0;
      check("d3_empty",  32'(b_vc_empty), 32'hF);
      check("d3_noerr",  32'({b_ovf, b_unf}), 32'h0);

      // ---- asynchronous reset mid-stream, away from any clock edge
      b_wr_valid = 1'b1; b_wr_data = 8'h55; tick(); b_wr_valid = 1'b0;
      check("pre_rst_b", 32'(b_vc_count[1*CB +: CB]), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("arst_empty_a", 32'(a_vc_empty), 32'hF);
      check("arst_count_a", 32'(a_vc_count), 32'h0);
      check("arst_empty_b", 32'(b_vc_empty), 32'hF);
      check("arst_count_b", 32'(b_vc_count), 32'h0);
      check("arst_cred_a",  32'(a_credit_valid), 32'h0);
      check("arst_errs_a",  32'({a_ovf, a_unf}), 32'h0);
      tick();
      reset = 1'b1;
      tick();
      check("post_rst_full", 32'(a_vc_full), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_vc_input_buffer

`default_nettype wire

// File: doc/vc_input_buffer.md
Name: vc_input_buffer

Overview:
- Per-input-port flit buffer for the virtual channel router: NUM_VC independent FIFOs behind one write port and one read port.
- Writes are tagged by VC id. Reads select a VC and present its head flit first-word-fall-through.
- Tracks occupancy per VC with explicit counters and returns one credit upstream per dequeued flit.
- Sits between the link receiver and the route-compute / VC-allocation stages.

Parameters:
- NUM_VC, 4, number of virtual channels.
- VC_DEPTH, 4, flits per VC; any value >= 2, not restricted to a power of two.
- DATA_WIDTH, `FLIT_DATA_WIDTH, flit width in bits.
- AFULL_THRESH, VC_DEPTH-1, vc_almost_full asserts when count >= this value.
- VC_ID_W, $clog2(NUM_VC) (minimum 1), width of VC index.
- CNT_W, $clog2(VC_DEPTH+1), width of one occupancy count.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- wr_valid  input  1  flit present on the write port.
- wr_vc  input  VC_ID_W  target VC of the write.
- wr_data  input  DATA_WIDTH  flit to enqueue.
- rd_pop  input  1  dequeue the head of rd_vc.
- rd_vc  input  VC_ID_W  VC selected for read.
- rd_data  output  DATA_WIDTH  head flit of rd_vc, combinational.
- vc_empty  output  NUM_VC  per-VC empty.
- vc_full  output  NUM_VC  per-VC full.
- vc_almost_full  output  NUM_VC  per-VC count >= AFULL_THRESH.
- vc_count  output  NUM_VC*CNT_W  packed per-VC occupancy; VC i occupies bits [i*CNT_W +: CNT_W].
- credit_valid  output  1  registered one-cycle pulse per accepted pop.
- credit_vc  output  VC_ID_W  VC the credit belongs to.
- overflow_err  output  1  sticky: rejected write.
- underflow_err  output  1  sticky: rejected pop.
- clear_err  input  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (asynchronous, on reset=0):
  - all pointers and counts = 0; vc_empty = all 1s; vc_full = 0; vc_almost_full = 0 (unless AFULL_THRESH = 0).
  - credit_valid = 0; credit_vc = 0; both error flags = 0.
  - Storage array is not reset. rd_data is don't-care while vc_empty[rd_vc] = 1.
  - Reset mid-operation discards all flits immediately; no credits are issued for discarded flits.
- Full, empty and almost-full are derived from the count registers only, never from pointer equality.
- Write acceptance: accepted iff wr_valid && wr_vc < NUM_VC && !vc_full[wr_vc]. Full is evaluated on current registered state.
  - Accepted write: store at wr_ptr[wr_vc]; wr_ptr wraps VC_DEPTH-1 -> 0.
- Pop acceptance: accepted iff rd_pop && rd_vc < NUM_VC && !vc_empty[rd_vc].
  - Accepted pop: rd_ptr[rd_vc] advances with the same wrap rule.
- Counter update per VC, same cycle: +1 on accepted write only, -1 on accepted pop only, unchanged on both.
- Different VCs may write and pop in the same cycle independently.
- Same VC, simultaneous write and pop:
  - empty VC: pop rejected (no bypass); write accepted; count becomes 1.
  - full VC: write rejected; pop accepted; count becomes VC_DEPTH-1.
  - otherwise: both accepted; count unchanged.
- Latency: an accepted write is visible on rd_data (when rd_vc selects it) and in vc_count the next cycle.
- Credits:
  - credit_valid = 1 in cycle N+1 for an accepted pop in cycle N, with credit_vc = rd_vc from cycle N.
  - At most one credit per cycle; back-to-back pops give a continuous credit stream.
- Error flags:
  - overflow_err sets on wr_valid that is not accepted (full VC or out-of-range wr_vc).
  - underflow_err sets on rd_pop that is not accepted.
  - Flags hold until clear_err = 1. If clear and set occur in the same cycle, set wins.
- No state machine beyond the per-VC pointer/count registers.

Decomposition:
- Shared package router_pkg: flit width constant (mirroring `FLIT_DATA_WIDTH`), vc_id_t typedef, default NUM_VC / VC_DEPTH.
- Sub-module vc_fifo_slice: one VC with storage, rd/wr pointers, count, and empty/full/almost_full.
  - Inputs: push and pop qualifiers.
  - Outputs: head data and status.
  - Instantiated NUM_VC times via generate.
- Top level holds VC decode, read mux, credit register, error flags and vc_count packing.

Test Plan:
- Reset, then write 0xA1, 0xA2, 0xA3 to VC2; rd_vc=2 -> rd_data=0xA1; vc_count[VC2]=3; all other VC counts 0.
- VC_DEPTH=4: write 5 flits to VC1 -> vc_full[1]=1 after the 4th; 5th rejected; overflow_err=1; vc_almost_full[1]=1 from count 3 onward.
- Pop an empty VC0 -> underflow_err=1, no credit_valid; clear_err=1 for one cycle -> flag returns to 0.
- Same-cycle write to VC3 and pop from VC3 at count 2 -> count stays 2; pop at cycle N gives credit_valid=1 and credit_vc=3 at N+1.
- Same-cycle write/pop on empty VC0 -> pop rejected, count 1, underflow_err=1; then on full VC0 -> write rejected, count 3, overflow_err=1.
- VC_DEPTH=3 (non-power-of-2): 10 interleaved push/pop cycles -> data order preserved across pointer wrap.
- Assert reset=0 mid-stream -> all counts 0 and vc_empty all 1s in the same cycle, independent of clk.
